// File: rtl/fetch_pkg.sv
// Shared widths, constants and the queue entry type for the fetch stage.
// Counter width leaves room for the value DEPTH itself (clog2 + 1 bits).
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Memory-side request/response and core-side instruction handshake of the fetch stage.
// master = fetch_buffer, slave = instruction memory plus core.
interface fetch_buffer_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               inst_valid;
  logic [INSTR_W-1:0] inst_data;
  logic [31:0]        inst_pc;
  logic               inst_ready;
  logic               redirect;
  logic [31:0]        redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Queue of {pc, instr} entries: write visible next cycle, head read combinationally.
// Push and pop in one cycle both honoured; flush empties it but keeps storage contents.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_dat,
  input  logic          pop,
  output fetch_entry_t  head_dat,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            do_push;
  logic            do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_dat = mem[head];

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= push_dat;
        tail      <= tail + 1'b1;
      end
      if (do_pop) head <= head + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Prefetch stage: issues sequential word reads, queues responses, presents them to the core.
// Instruction valid L+1 cycles after request; requests stall while queued+in-flight+dropped == DEPTH.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic           clock,
  input  logic           Reset,
  fetch_buffer_if.master bus
);

  localparam int CW = cnt_w(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW+1:0] in_use;
  logic          issue;
  logic          resp_live;
  logic          resp_drop;
  logic          resp_take;
  fetch_entry_t  push_dat;
  fetch_entry_t  head_dat;

  // Every slot is reserved at issue time, so a response can never find the queue full.
  assign in_use    = {2'b00, count} + {2'b00, outstanding} + {2'b00, drop};
  assign issue     = !Reset && !bus.redirect && (in_use < (CW+2)'(DEPTH));
  assign target_pc = bus.redirect_pc & ~32'h3;

  // A response with nothing outstanding is ignored outright.
  assign resp_live = bus.imem_rvalid && ((drop != '0) || (outstanding != '0));
  assign resp_drop = bus.imem_rvalid && (drop != '0);
  assign resp_take = bus.imem_rvalid && (drop == '0) && (outstanding != '0);

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (bus.redirect) begin
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      outstanding <= '0;
      drop        <= drop + outstanding - CW'(resp_live);
    end else begin
      if (issue)     fetch_pc <= fetch_pc + PC_INC;
      if (resp_take) resp_pc  <= resp_pc + PC_INC;
      outstanding <= outstanding + CW'(issue) - CW'(resp_take);
      drop        <= drop - CW'(resp_drop);
    end
  end

  assign push_dat.pc    = resp_pc;
  assign push_dat.instr = bus.imem_rdata;

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clock    (clock),
    .Reset    (Reset),
    .flush    (bus.redirect),
    .push     (resp_take && !bus.redirect),
    .push_dat (push_dat),
    .pop      (bus.inst_valid && bus.inst_ready && !bus.redirect),
    .head_dat (head_dat),
    .count    (count)
  );

  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = head_dat.instr;
  assign bus.inst_pc    = head_dat.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: in-order variable-latency memory model plus an epoch-tagged
// scoreboard of what the core must see; directed scenarios followed by random traffic.
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clock = 1'b0;
  logic Reset = 1'b1;
  always #5 clock = ~clock;

  fetch_buffer_if bus ();

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  exp_fetch_pc;
  int           epoch, cyc, lat;
  int           n_checks, n_pass;
  logic         drv_redirect, drv_ready;
  logic [31:0]  drv_rpc;
  logic         obs_req, obs_valid;
  logic [31:0]  obs_addr, obs_pc, obs_data;

  // Memory content is a scrambled copy of the address so pc and data are distinguishable.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    logic  rv;
    logic  exp_req;
    mreq_t r;
    @(negedge clock);
    rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    if (rv) assert (mem_q.size() != 0) else $error("rvalid with no request outstanding");
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? word_at(mem_q[0].addr) : $urandom();
    bus.redirect    = drv_redirect;
    bus.redirect_pc = drv_rpc;
    bus.inst_ready  = drv_ready;
    #1;
    obs_req   = bus.imem_req;
    obs_addr  = bus.imem_addr;
    obs_valid = bus.inst_valid;
    obs_pc    = bus.inst_pc;
    obs_data  = bus.inst_data;
    exp_req   = !drv_redirect && ((exp_q.size() + mem_q.size()) < DEPTH);
    check_eq("imem_req", 32'(obs_req), 32'(exp_req));
    if (obs_req) check_eq("imem_addr", obs_addr, exp_fetch_pc);
    check_eq("inst_valid", 32'(obs_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("inst_pc", obs_pc, exp_q[0].pc);
      check_eq("inst_data", obs_data, exp_q[0].instr);
    end
    if (!drv_redirect && drv_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (rv) begin
      r = mem_q.pop_front();
      if (!drv_redirect && r.epoch == epoch)
        exp_q.push_back('{pc: r.addr, instr: word_at(r.addr)});
    end
    if (obs_req) mem_q.push_back('{addr: obs_addr, epoch: epoch, due: cyc + lat});
    if (drv_redirect) begin
      epoch++;
      exp_q.delete();
      exp_fetch_pc = drv_rpc & ~32'h3;
    end else if (obs_req) begin
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    @(posedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    Reset           = 1'b1;
    mem_q.delete();
    exp_q.delete();
    epoch++;
    exp_fetch_pc    = RST_PC;
    drv_redirect    = 1'b0;
    drv_ready       = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.redirect    = 1'b0;
    bus.inst_ready  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_addr", bus.imem_addr, RST_PC);
    check_eq("rst_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("rst_pc", bus.inst_pc, 32'd0);
    check_eq("rst_data", bus.inst_data, 32'd0);
    @(posedge clock);
    #2 Reset = 1'b0;
  endtask

  logic [31:0] wrap_seq [3];
  int nreq, found, na, np;

  initial begin
    n_checks = 0; n_pass = 0; epoch = 0; cyc = 0; lat = 1;
    drv_redirect = 1'b0; drv_ready = 1'b0; drv_rpc = '0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b0;

    // Streaming after reset, L=1, core always ready.
    do_reset();
    drv_ready = 1'b1; lat = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 1) check_eq("t1_valid_c1", 32'(obs_valid), 32'd0);
      if (k == 2) begin
        check_eq("t1_valid_c2", 32'(obs_valid), 32'd1);
        check_eq("t1_pc_c2", obs_pc, 32'h0);
        check_eq("t1_data_c2", obs_data, word_at(32'h0));
      end
      if (k == 3) check_eq("t1_pc_c3", obs_pc, 32'h4);
      if (k == 4) check_eq("t1_pc_c4", obs_pc, 32'h8);
    end

    // Core stalled: exactly DEPTH requests, then one pop frees one slot.
    do_reset();
    drv_ready = 1'b0; lat = 1; nreq = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      nreq += int'(obs_req);
      if (k == 3) check_eq("t2_addr_c3", obs_addr, 32'hC);
    end
    check_eq("t2_req_total", 32'(nreq), 32'd4);
    drv_ready = 1'b1;
    step();
    check_eq("t2_pop_pc", obs_pc, 32'h0);
    check_eq("t2_full_req", 32'(obs_req), 32'd0);
    drv_ready = 1'b0;
    step();
    check_eq("t2_refill_req", 32'(obs_req), 32'd1);
    check_eq("t2_refill_addr", obs_addr, 32'h10);

    // Asynchronous reset with three queued entries.
    #3 Reset = 1'b1;
    #1;
    check_eq("t6_async_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("t6_async_pc", bus.inst_pc, 32'd0);
    check_eq("t6_async_data", bus.inst_data, 32'd0);
    do_reset();
    step();
    check_eq("t6_restart_req", 32'(obs_req), 32'd1);
    check_eq("t6_restart_addr", obs_addr, RST_PC);

    // L=3, three in flight, redirect to an unaligned target.
    do_reset();
    drv_ready = 1'b1; lat = 3;
    repeat (3) step();
    drv_redirect = 1'b1; drv_rpc = 32'h0000_0103;
    step();
    check_eq("t3_redir_req", 32'(obs_req), 32'd0);
    drv_redirect = 1'b0;
    step();
    check_eq("t3_new_addr", obs_addr, 32'h100);
    found = 0;
    for (int k = 0; k < 15 && found == 0; k++) begin
      step();
      if (obs_valid) begin
        found = 1;
        check_eq("t3_first_pc", obs_pc, 32'h100);
        check_eq("t3_first_data", obs_data, word_at(32'h100));
      end
    end
    check_eq("t3_found", 32'(found), 32'd1);

    // Redirect coinciding with a response and a pop while two entries are queued.
    do_reset();
    drv_ready = 1'b0; lat = 2;
    repeat (4) step();
    drv_redirect = 1'b1; drv_ready = 1'b1; drv_rpc = 32'h0000_2000;
    step();
    check_eq("t4_head_pc", obs_pc, 32'h0);
    drv_redirect = 1'b0;
    step();
    check_eq("t4_flushed", 32'(obs_valid), 32'd0);
    check_eq("t4_new_addr", obs_addr, 32'h2000);
    found = 0;
    for (int k = 0; k < 15 && found == 0; k++) begin
      step();
      if (obs_valid) begin
        found = 1;
        check_eq("t4_first_pc", obs_pc, 32'h2000);
      end
    end
    check_eq("t4_found", 32'(found), 32'd1);

    // fetch_pc wraps modulo 2^32.
    wrap_seq[0] = 32'hFFFF_FFF8; wrap_seq[1] = 32'hFFFF_FFFC; wrap_seq[2] = 32'h0000_0000;
    drv_ready = 1'b1; lat = 1;
    drv_redirect = 1'b1; drv_rpc = 32'hFFFF_FFF8;
    step();
    drv_redirect = 1'b0; na = 0; np = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (obs_req && na < 3) begin check_eq("t5_addr", obs_addr, wrap_seq[na]); na++; end
      if (obs_valid && np < 3) begin check_eq("t5_pc", obs_pc, wrap_seq[np]); np++; end
    end
    check_eq("t5_addr_cnt", 32'(na), 32'd3);
    check_eq("t5_pc_cnt", 32'(np), 32'd3);

    // Random traffic against the scoreboard.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      drv_ready    = ($urandom_range(0, 3) != 0);
      lat          = $urandom_range(1, 5);
      drv_redirect = ($urandom_range(0, 19) == 0);
      drv_rpc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom();
      step();
    end
    drv_redirect = 1'b0; drv_ready = 1'b1;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
